// File: rtl/pill_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pill_feeder
// Purpose  : Pill-drop pulse source. Paces pills every DIV cycles, performs a
//            SWAP_CYCLES bottle change after each BCD pills-per-bottle target,
//            and stops in DONE after the BCD bottle target. Drives BCD pill
//            and bottle counts for display. All outputs are registered.
// Options  : PILL_FEEDER_JAM_EN - jam sensor pauses feeding and sets jam_err.
// Revision : 1.0 - initial release
// ============================================================================
module pill_feeder #(
  parameter int DIV         = 4,
  parameter int SWAP_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  input  logic [3:0] bot_maxL,
  input  logic [3:0] bot_maxH,
  input  logic       jam,
  output logic       pill,
  output logic       bottle_done,
  output logic [3:0] pillL,
  output logic [3:0] pillH,
  output logic [3:0] botL,
  output logic [3:0] botH,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic       jam_err
);

  localparam int DW = $clog2(DIV);
  localparam int SW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SWAP_LAST = SW'(SWAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_SWAP  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d, saved_q, saved_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] swap_q, swap_d;
  logic [7:0]    tgt_pill_q, tgt_pill_d, tgt_bot_q, tgt_bot_d;
  logic [7:0]    cnt_q, cnt_d, bot_q, bot_d;
  logic          pill_q, pill_d, bdone_q, bdone_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          cfg_err_q, cfg_err_d, jam_err_q, jam_err_d;

  logic          w_jam;
  logic          w_halt_feed;
  logic          w_go;
  logic [7:0]    w_cnt_inc, w_bot_inc;

`ifdef PILL_FEEDER_JAM_EN
  assign w_jam = jam;
`else
  logic unused_jam;
  assign unused_jam = jam;
  assign w_jam      = 1'b0;
`endif

  // stop beats start; a jam (when enabled) also blocks start
  assign w_halt_feed = stop | w_jam;
  assign w_go        = start & ~stop & ~w_jam;

  // Digits above 9 are treated as 9
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Two-digit BCD increment; callers never pass 99 (targets cap the count)
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign w_cnt_inc = bcd_inc(cnt_q);
  assign w_bot_inc = bcd_inc(bot_q);

  // Next-state and next-output logic for the feeder sequencer
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    div_d      = div_q;
    swap_d     = swap_q;
    tgt_pill_d = tgt_pill_q;
    tgt_bot_d  = tgt_bot_q;
    cnt_d      = cnt_q;
    bot_d      = bot_q;
    cfg_err_d  = cfg_err_q;
    jam_err_d  = jam_err_q;
    pill_d     = 1'b0;
    bdone_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_go) begin
          tgt_pill_d = {clamp9(maxH), clamp9(maxL)};
          tgt_bot_d  = {clamp9(bot_maxH), clamp9(bot_maxL)};
          cnt_d      = 8'h00;
          bot_d      = 8'h00;
          div_d      = '0;
          swap_d     = '0;
          if (tgt_pill_d == 8'h00 || tgt_bot_d == 8'h00) begin
            cfg_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = S_FEED;
          end
        end
      end

      S_FEED: begin
        if (div_q == DIV_LAST) begin
          // Pill is on the output this cycle: account for it even if halted.
          // A completed bottle always enters SWAP; a halt then applies there.
          cnt_d = w_cnt_inc;
          div_d = '0;
          if (w_cnt_inc == tgt_pill_q) begin
            state_d = S_SWAP;
            swap_d  = '0;
            bdone_d = 1'b1;
            bot_d   = w_bot_inc;
          end else if (w_halt_feed) begin
            state_d   = S_PAUSE;
            saved_d   = S_FEED;
            jam_err_d = jam_err_q | w_jam;
          end
        end else if (w_halt_feed) begin
          state_d   = S_PAUSE;
          saved_d   = S_FEED;
          jam_err_d = jam_err_q | w_jam;
        end else begin
          div_d  = div_q + DW'(1);
          pill_d = ((div_q + DW'(1)) == DIV_LAST);
        end
      end

      S_SWAP: begin
        if (stop) begin
          state_d = S_PAUSE;
          saved_d = S_SWAP;
        end else if (swap_q == SWAP_LAST) begin
          if (bot_q == tgt_bot_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
            cnt_d   = 8'h00;
            div_d   = '0;
          end
        end else begin
          swap_d = swap_q + SW'(1);
        end
      end

      S_PAUSE: begin
        // The frozen divider is never at DIV_LAST, so resume emits no pill
        if (w_go) begin
          state_d   = saved_q;
          jam_err_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FEED) || (state_d == S_SWAP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      saved_q    <= S_IDLE;
      div_q      <= '0;
      swap_q     <= '0;
      tgt_pill_q <= 8'h00;
      tgt_bot_q  <= 8'h00;
      cnt_q      <= 8'h00;
      bot_q      <= 8'h00;
      pill_q     <= 1'b0;
      bdone_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      jam_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      div_q      <= div_d;
      swap_q     <= swap_d;
      tgt_pill_q <= tgt_pill_d;
      tgt_bot_q  <= tgt_bot_d;
      cnt_q      <= cnt_d;
      bot_q      <= bot_d;
      pill_q     <= pill_d;
      bdone_q    <= bdone_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      jam_err_q  <= jam_err_d;
    end
  end

  assign pill        = pill_q;
  assign bottle_done = bdone_q;
  assign pillL       = cnt_q[3:0];
  assign pillH       = cnt_q[7:4];
  assign botL        = bot_q[3:0];
  assign botH        = bot_q[7:4];
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign jam_err     = jam_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pill_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pill_feeder
// Purpose  : Scoreboard bench for pill_feeder. A behavioural model predicts
//            pill / bottle_done pulses and status; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pill_feeder;
  localparam int DIV         = 4;
  localparam int SWAP_CYCLES = 3;

  logic       CLK = 1'b0, RST = 1'b0, start = 1'b0, stop = 1'b0, jam = 1'b0;
  logic [3:0] maxL = 4'd0, maxH = 4'd0, bot_maxL = 4'd0, bot_maxH = 4'd0;
  logic       pill, bottle_done, busy, done, cfg_err, jam_err;
  logic [3:0] pillL, pillH, botL, botH;

  pill_feeder #(.DIV(DIV), .SWAP_CYCLES(SWAP_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop),
    .maxL(maxL), .maxH(maxH), .bot_maxL(bot_maxL), .bot_maxH(bot_maxH),
    .jam(jam), .pill(pill), .bottle_done(bottle_done),
    .pillL(pillL), .pillH(pillH), .botL(botL), .botH(botH),
    .busy(busy), .done(done), .cfg_err(cfg_err), .jam_err(jam_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef enum int {M_IDLE, M_FEED, M_SWAP, M_PAUSE, M_DONE} mode_t;
  typedef struct {int kind; int val; int due;} ev_t;  // kind 0 = pill, 1 = bottle
  ev_t sbq[$];

  // Reference model: integer counts, countdown to next pill
  mode_t m_mode = M_IDLE, m_saved = M_IDLE;
  int m_tp = 0, m_tb = 0, m_pills = 0, m_bots = 0, m_left = 0, m_swap_left = 0;
  bit m_cfg = 0, m_jerr = 0;

  function automatic int c9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_mode = M_IDLE; m_saved = M_IDLE; m_tp = 0; m_tb = 0;
        m_pills = 0; m_bots = 0; m_left = 0; m_swap_left = 0;
        m_cfg = 0; m_jerr = 0;
        sbq.delete();
      end else begin
        bit jam_act, halt, go, npill, nbd;
`ifdef PILL_FEEDER_JAM_EN
        jam_act = jam;
`else
        jam_act = 1'b0;
`endif
        halt  = stop || jam_act;
        go    = start && !stop && !jam_act;
        npill = 0;
        nbd   = 0;
        cyc++;
        case (m_mode)
          M_IDLE, M_DONE: if (go) begin
            m_tp = 10 * c9(maxH) + c9(maxL);
            m_tb = 10 * c9(bot_maxH) + c9(bot_maxL);
            m_pills = 0; m_bots = 0;
            m_cfg = (m_tp == 0) || (m_tb == 0);
            if (m_cfg) m_mode = M_IDLE;
            else begin m_mode = M_FEED; m_left = DIV; end
          end
          M_FEED: begin
            if (m_left == 1) begin
              m_pills++;
              m_left = DIV;
              if (m_pills == m_tp) begin
                m_bots++; m_mode = M_SWAP; m_swap_left = SWAP_CYCLES; nbd = 1;
              end else if (halt) begin
                m_mode = M_PAUSE; m_saved = M_FEED; if (jam_act) m_jerr = 1;
              end
            end else if (halt) begin
              m_mode = M_PAUSE; m_saved = M_FEED; if (jam_act) m_jerr = 1;
            end else begin
              m_left--;
              if (m_left == 1) npill = 1;
            end
          end
          M_SWAP: begin
            if (stop) begin
              m_mode = M_PAUSE; m_saved = M_SWAP;
            end else if (m_swap_left == 1) begin
              if (m_bots == m_tb) m_mode = M_DONE;
              else begin m_mode = M_FEED; m_pills = 0; m_left = DIV; end
            end else m_swap_left--;
          end
          M_PAUSE: if (go) begin m_mode = m_saved; m_jerr = 0; end
          default: m_mode = M_IDLE;
        endcase
        if (npill) sbq.push_back('{0, m_pills, cyc});
        if (nbd)   sbq.push_back('{1, m_bots, cyc});
      end
    end
  end

  function automatic logic [19:0] exp_status();
    return {(m_mode == M_FEED || m_mode == M_SWAP), (m_mode == M_DONE), m_cfg, m_jerr,
            to_bcd(m_pills), to_bcd(m_bots)};
  endfunction

  // Monitor: status every cycle, pulses popped from the scoreboard
  initial begin
    forever begin
      ev_t ev;
      @(negedge CLK);
      check("status", {12'd0, busy, done, cfg_err, jam_err, pillH, pillL, botH, botL}, {12'd0, exp_status()});
      if (pill || bottle_done) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: got pill=%0b bottle_done=%0b expected no pulse (cycle %0d)",
                   pill, bottle_done, cyc);
        end else begin
          ev = sbq.pop_front();
          check("pulse_kind", {30'd0, pill, bottle_done}, (ev.kind == 0) ? 32'd2 : 32'd1);
          check("pulse_cycle", cyc, ev.due);
          check("pulse_count", (ev.kind == 0) ? {24'd0, pillH, pillL} : {24'd0, botH, botL},
                {24'd0, to_bcd(ev.val)});
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        ev = sbq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_pulse: got none expected kind %0d count %0d (cycle %0d)", ev.kind, ev.val, ev.due);
      end
    end
  end

  task automatic set_targets(input logic [3:0] ph, input logic [3:0] pl,
                             input logic [3:0] bh, input logic [3:0] bl);
    maxH = ph; maxL = pl; bot_maxH = bh; bot_maxL = bl;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(m_mode == M_DONE || m_mode == M_IDLE) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle_timeout: got %0d cycles expected completion", n);
    end
  endtask

  initial begin
    int n;
    #1 RST = 1'b1;
    cycles(3);
    check("reset_outs", {10'd0, pill, bottle_done, busy, done, cfg_err, jam_err, pillH, pillL, botH, botL}, 32'd0);
    RST = 1'b0;
    cycles(2);

    // 3 pills per bottle, 2 bottles
    set_targets(4'd0, 4'd3, 4'd0, 4'd2);
    pulse_start();
    wait_idle(200);
    check("s1_done", {31'd0, done}, 32'd1);
    check("s1_botL", {28'd0, botL}, 32'd2);
    check("s1_pillL", {28'd0, pillL}, 32'd3);

    // 12 pills, restart from DONE
    set_targets(4'd1, 4'd2, 4'd0, 4'd1);
    pulse_start();
    wait_idle(200);
    check("s2_pills", {24'd0, pillH, pillL}, 32'h12);

    // zero pill target
    set_targets(4'd0, 4'd0, 4'd0, 4'd1);
    pulse_start();
    cycles(20);
    check("s3_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("s3_busy", {31'd0, busy}, 32'd0);

    // stop after 2 pills for 10 cycles
    set_targets(4'd0, 4'd5, 4'd0, 4'd1);
    pulse_start();
    n = 0;
    while ({pillH, pillL} != 8'h02 && n < 100) begin @(negedge CLK); n++; end
    check("s4_reach_2", {31'd0, n >= 100}, 32'd0);
    stop = 1'b1;
    cycles(10);
    check("s4_frozen", {24'd0, pillH, pillL}, 32'h02);
    stop = 1'b0;
    pulse_start();
    wait_idle(200);

    // stop and start together in FEED
    set_targets(4'd0, 4'd4, 4'd0, 4'd1);
    pulse_start();
    cycles(5);
    stop = 1'b1; start = 1'b1;
    cycles(1);
    stop = 1'b0; start = 1'b0;
    check("s5_paused", {31'd0, busy}, 32'd0);
    pulse_start();
    wait_idle(200);

    // reset in the middle of SWAP
    set_targets(4'd0, 4'd2, 4'd0, 4'd2);
    pulse_start();
    n = 0;
    while (!bottle_done && n < 100) begin @(negedge CLK); n++; end
    check("s6_reach_swap", {31'd0, n >= 100}, 32'd0);
    #2 RST = 1'b1;
    #1 check("s6_reset_outs", {10'd0, pill, bottle_done, busy, done, cfg_err, jam_err, pillH, pillL, botH, botL}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    cycles(2);

    // jam behaviour
    set_targets(4'd0, 4'd5, 4'd0, 4'd1);
    pulse_start();
`ifdef PILL_FEEDER_JAM_EN
    cycles(5);
    jam = 1'b1;
    cycles(1);
    check("jam_err_set", {31'd0, jam_err}, 32'd1);
    start = 1'b1;
    cycles(3);
    check("jam_start_ignored", {31'd0, busy}, 32'd0);
    jam = 1'b0;
    cycles(1);
    start = 1'b0;
    check("jam_resume", {30'd0, busy, jam_err}, 32'd2);
    wait_idle(200);
`else
    jam = 1'b1;
    wait_idle(200);
    jam = 1'b0;
    check("jam_ignored_done", {30'd0, done, jam_err}, 32'd2);
`endif

    // randomized episodes; targets and controls keep changing mid-run
    for (int ep = 0; ep < 16; ep++) begin
      set_targets(4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'd0, 4'($urandom_range(0, 3)));
      pulse_start();
      n = 0;
      while (!(m_mode == M_DONE || m_mode == M_IDLE) && n < 3000) begin
        stop  = ($urandom_range(0, 19) == 0);
        start = ($urandom_range(0, 5) == 0);
        jam   = ($urandom_range(0, 9) == 0);
        set_targets(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        @(negedge CLK);
        n++;
      end
      stop = 1'b0; start = 1'b0; jam = 1'b0;
      if (n >= 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL random_timeout: got %0d cycles expected completion (episode %0d)", n, ep);
      end
      cycles(2);
    end

    cycles(5);
    check("queue_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
